// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Request/acknowledge front end of an 8237A-style DMA controller. It merges
//   hardware DREQ and software requests, applies masking and fixed or rotating
//   priority, runs the HRQ/HLDA handshake with the CPU and drives one-hot DACK
//   to the transfer-mode stage.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous active-high reset
//   DREQ[3:0]         hardware requests (sense chosen by command_register[6])
//   command_register  [2] disable, [4] rotating priority, [6] DREQ active-low
//   mask_register     1 = hardware DREQ of that channel ignored
//   request_register  software requests, never masked
//   channel_mode      2 bits per channel: 00 demand, 01 single, 10 block, 11 single
//   HLDA              hold acknowledge from CPU
//   TC                terminal count (level)
//   EOP_in            external end of process, active-high
//   xfer_done         one-cycle pulse per completed transfer
//   HRQ               hold request to CPU
//   DACK0..DACK3      one-hot channel acknowledge
//   active_channel    channel in service, valid while a DACK is high
//   sw_req_clr        one-cycle pulse clearing the served software request
//   busy              high whenever the FSM is not idle
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         DREQ,
    input  logic [7:0]                command_register,
    input  logic [NUM_CH-1:0]         mask_register,
    input  logic [NUM_CH-1:0]         request_register,
    input  logic [2*NUM_CH-1:0]       channel_mode,
    input  logic                      HLDA,
    input  logic                      TC,
    input  logic                      EOP_in,
    input  logic                      xfer_done,
    output logic                      HRQ,
    output logic                      DACK0,
    output logic                      DACK1,
    output logic                      DACK2,
    output logic                      DACK3,
    output logic [$clog2(NUM_CH)-1:0] active_channel,
    output logic [NUM_CH-1:0]         sw_req_clr,
    output logic                      busy
);

    localparam int unsigned ChW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        StIdle,
        StHoldReq,
        StActive,
        StRelease
    } state_e;

    state_e            state_q;
    logic [NUM_CH-1:0] dack_q;
    logic [ChW-1:0]    ch_q;    // channel locked in for the current service
    logic [ChW-1:0]    ptr_q;   // highest-priority channel when rotating

    logic ctrl_disable;
    logic rotate;
    logic dreq_low;
    logic unused_cmd;

    assign ctrl_disable = command_register[2];
    assign rotate       = command_register[4];
    assign dreq_low     = command_register[6];
    assign unused_cmd   = ^{command_register[7], command_register[5],
                            command_register[3], command_register[1:0]};

    logic [NUM_CH-1:0] hw_req;
    logic [NUM_CH-1:0] eff;

    assign hw_req = dreq_low ? ~DREQ : DREQ;
    assign eff    = (hw_req & ~mask_register) | request_register;

    // Priority search: start at the pointer (or channel 0 when fixed) and take
    // the first effective request. Index arithmetic wraps since NUM_CH is 2^ChW.
    logic [ChW-1:0] arb_base;
    logic [ChW-1:0] arb_idx;
    logic [ChW-1:0] win;
    logic           found;

    always_comb begin
        arb_base = rotate ? ptr_q : '0;
        arb_idx  = '0;
        win      = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = arb_base + ChW'(i);
            if (!found && eff[arb_idx]) begin
                win   = arb_idx;
                found = 1'b1;
            end
        end
    end

    // End-of-service decode for the locked channel.
    logic [1:0] cur_mode;
    logic       svc_end;

    assign cur_mode = channel_mode[{ch_q, 1'b0} +: 2];

    always_comb begin
        svc_end = 1'b0;
        case (cur_mode)
            2'b00:   svc_end = !eff[ch_q];   // demand: request withdrawn
            2'b10:   svc_end = 1'b0;         // block: only TC/EOP
            default: svc_end = xfer_done;    // single (01 and 11)
        endcase
        svc_end = svc_end | TC | EOP_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            dack_q         <= '0;
            ch_q           <= '0;
            ptr_q          <= '0;
            HRQ            <= 1'b0;
            active_channel <= '0;
            sw_req_clr     <= '0;
            busy           <= 1'b0;
        end else begin
            sw_req_clr <= '0;
            case (state_q)
                StIdle: begin
                    HRQ <= 1'b0;
                    // HRQ is raised one cycle after entering HOLD_REQ.
                    if (!ctrl_disable && found) begin
                        state_q <= StHoldReq;
                        busy    <= 1'b1;
                    end
                end
                StHoldReq: begin
                    if (ctrl_disable || !found) begin
                        state_q <= StIdle;
                        HRQ     <= 1'b0;
                        busy    <= 1'b0;
                    end else if (HLDA) begin
                        state_q        <= StActive;
                        HRQ            <= 1'b1;
                        ch_q           <= win;
                        active_channel <= win;
                        dack_q         <= NUM_CH'(1) << win;
                    end else begin
                        HRQ <= 1'b1;
                    end
                end
                StActive: begin
                    if (!HLDA) begin
                        // CPU reclaimed the bus: drop everything, no pointer update.
                        state_q <= StIdle;
                        HRQ     <= 1'b0;
                        dack_q  <= '0;
                        busy    <= 1'b0;
                    end else if (svc_end) begin
                        state_q    <= StRelease;
                        HRQ        <= 1'b0;
                        dack_q     <= '0;
                        sw_req_clr <= (NUM_CH'(1) << ch_q) & request_register;
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                    ptr_q   <= ch_q + ChW'(1);
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    HRQ     <= 1'b0;
                    dack_q  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign DACK0 = dack_q[0];
    assign DACK1 = dack_q[1];
    assign DACK2 = dack_q[2];
    assign DACK3 = dack_q[3];

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] DREQ;
    logic [7:0] command_register;
    logic [3:0] mask_register;
    logic [3:0] request_register;
    logic [7:0] channel_mode;
    logic       HLDA;
    logic       TC;
    logic       EOP_in;
    logic       xfer_done;
    logic       HRQ;
    logic       DACK0, DACK1, DACK2, DACK3;
    logic [1:0] active_channel;
    logic [3:0] sw_req_clr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int grant_q[$];   // expected channel of each upcoming grant
    int clr_q[$];     // expected sw_req_clr pulses

    logic [3:0] prev_dack = 4'b0;

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .DREQ             (DREQ),
        .command_register (command_register),
        .mask_register    (mask_register),
        .request_register (request_register),
        .channel_mode     (channel_mode),
        .HLDA             (HLDA),
        .TC               (TC),
        .EOP_in           (EOP_in),
        .xfer_done        (xfer_done),
        .HRQ              (HRQ),
        .DACK0            (DACK0),
        .DACK1            (DACK1),
        .DACK2            (DACK2),
        .DACK3            (DACK3),
        .active_channel   (active_channel),
        .sw_req_clr       (sw_req_clr),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int dack_vec();
        return int'({DACK3, DACK2, DACK1, DACK0});
    endfunction

    // Monitor: compares each new grant and each sw_req_clr pulse to the scoreboard.
    always @(negedge clk) begin
        logic [3:0] d;
        int e;
        d = {DACK3, DACK2, DACK1, DACK0};
        if (d != 4'b0 && prev_dack == 4'b0) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", int'(d), 0);
            end else begin
                e = grant_q.pop_front();
                check("grant_dack", int'(d), 1 << e);
                check("grant_channel", int'(active_channel), e);
            end
        end
        if (sw_req_clr != 4'b0) begin
            if (clr_q.size() == 0) begin
                check("unexpected_sw_req_clr", int'(sw_req_clr), 0);
            end else begin
                e = clr_q.pop_front();
                check("sw_req_clr", int'(sw_req_clr), e);
            end
        end
        prev_dack = d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for HRQ, answer with HLDA two cycles later, wait for the DACK.
    task automatic grant(input int ch);
        bit seen;
        grant_q.push_back(ch);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (HRQ) seen = 1'b1;
        end
        check("hrq_seen", int'(seen), 1);
        repeat (2) @(posedge clk);
        #1;
        HLDA = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (dack_vec() != 0) seen = 1'b1;
        end
        check("dack_seen", int'(seen), 1);
    endtask

    // One single-mode transfer; returns just after the edge into RELEASE.
    task automatic end_single();
        step();
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        HLDA      = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        DREQ             = 4'b0;
        command_register = 8'h00;
        mask_register    = 4'b0;
        request_register = 4'b0;
        channel_mode     = 8'h55;
        HLDA             = 1'b0;
        TC               = 1'b0;
        EOP_in           = 1'b0;
        xfer_done        = 1'b0;

        step();
        check("reset_hrq", int'(HRQ), 0);
        check("reset_dack", dack_vec(), 0);
        check("reset_active_channel", int'(active_channel), 0);
        check("reset_sw_req_clr", int'(sw_req_clr), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        step();

        // Fixed priority, single mode: ch1 beats ch3, then ch3.
        DREQ = 4'b1010;
        step();
        check("hold_req_hrq_lag", int'(HRQ), 0);
        check("hold_req_busy", int'(busy), 1);
        step();
        check("hold_req_hrq", int'(HRQ), 1);
        grant(1);
        end_single();
        check("release_hrq", int'(HRQ), 0);
        check("release_dack", dack_vec(), 0);
        check("release_busy", int'(busy), 1);
        DREQ = 4'b1000;
        grant(3);
        end_single();
        DREQ = 4'b0;
        step();

        // Rotating priority: ch2, then all four -> 3, 0, 1, 2.
        command_register = 8'h10;
        DREQ = 4'b0100;
        grant(2);
        end_single();
        DREQ = 4'b1111;
        grant(3);
        end_single();
        grant(0);
        end_single();
        grant(1);
        end_single();
        grant(2);
        end_single();
        DREQ = 4'b0;
        command_register = 8'h00;
        step();

        // Block mode ch0: DREQ drop ignored, TC ends service.
        channel_mode = 8'h02;
        DREQ = 4'b0001;
        grant(0);
        DREQ = 4'b0;
        repeat (3) step();
        check("block_dack_held", dack_vec(), 1);
        check("block_hrq_held", int'(HRQ), 1);
        TC = 1'b1;
        step();
        TC   = 1'b0;
        HLDA = 1'b0;
        check("block_tc_dack", dack_vec(), 0);
        check("block_tc_hrq", int'(HRQ), 0);
        check("block_tc_busy", int'(busy), 1);
        step();
        check("block_idle_busy", int'(busy), 0);
        check("block_idle_hrq", int'(HRQ), 0);
        step();

        // Demand mode ch1: DREQ withdrawal ends service.
        channel_mode = 8'h00;
        DREQ = 4'b0010;
        grant(1);
        step();
        DREQ = 4'b0;
        step();
        check("demand_drop_dack", dack_vec(), 0);
        check("demand_drop_hrq", int'(HRQ), 0);
        HLDA = 1'b0;

        // Active-low DREQ: only ch0 asserted (low).
        command_register = 8'h40;
        DREQ = 4'b1110;
        grant(0);
        step();
        DREQ = 4'b1111;
        step();
        check("demand_low_drop_dack", dack_vec(), 0);
        HLDA = 1'b0;
        step();
        command_register = 8'h00;
        DREQ = 4'b0;
        step();

        // Masking: masked DREQ ignored, software request honoured and cleared.
        channel_mode  = 8'h55;
        mask_register = 4'b0001;
        DREQ          = 4'b0001;
        repeat (6) step();
        check("masked_hrq", int'(HRQ), 0);
        check("masked_busy", int'(busy), 0);
        request_register = 4'b0001;
        clr_q.push_back(1);
        grant(0);
        end_single();
        request_register = 4'b0;
        step();
        check("sw_req_clr_one_cycle", int'(sw_req_clr), 0);
        mask_register = 4'b0;
        DREQ = 4'b0;
        step();

        // HLDA reclaim mid-service: no pointer update (pointer is 1 here).
        command_register = 8'h10;
        DREQ = 4'b0100;
        grant(2);
        step();
        HLDA = 1'b0;
        step();
        check("reclaim_dack", dack_vec(), 0);
        check("reclaim_hrq", int'(HRQ), 0);
        check("reclaim_busy", int'(busy), 0);
        DREQ = 4'b1111;
        grant(1);
        end_single();
        DREQ = 4'b0;
        command_register = 8'h00;
        step();

        // Controller disabled: requests blocked in IDLE.
        command_register = 8'h04;
        DREQ = 4'b0001;
        repeat (5) step();
        check("disabled_hrq", int'(HRQ), 0);
        check("disabled_busy", int'(busy), 0);
        DREQ = 4'b0;
        command_register = 8'h00;
        step();

        // Asynchronous reset while ACTIVE.
        DREQ = 4'b0001;
        grant(0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_hrq", int'(HRQ), 0);
        check("async_reset_dack", dack_vec(), 0);
        check("async_reset_busy", int'(busy), 0);
        step();
        DREQ  = 4'b0;
        HLDA  = 1'b0;
        reset = 1'b0;
        step();
        check("post_reset_busy", int'(busy), 0);

        check("grant_queue_empty", grant_q.size(), 0);
        check("clr_queue_empty", clr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
